treeval_core: RTL and testbench

TREEVAL_CORE -- requirements
Module: treeval

---
 rtl/treeval_pkg.sv | 38 +++
 rtl/treeval_node_mem.sv | 31 +++
 rtl/treeval_core.sv | 180 ++++++++++++++++++
 tb/tb_treeval_core.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/treeval_pkg.sv
// Shared widths, FSM states and node record for the tree evaluator.
// Imported by the node table and the core.
package treeval_pkg;

  localparam int W_ADDR   = 10;
  localparam int W_DATA   = 11;
  localparam int W_CONF   = 10;
  localparam int W_ACTION = 3;
  localparam int W_REWARD = 11;
  localparam int W_ACC    = 24;
  localparam int N_NODES  = 1024;
  localparam int N_ACT    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SELECT
  } state_e;

  typedef struct packed {
    logic [W_ADDR-1:0]          parent;
    logic [W_ACTION-1:0]        action;
    logic signed [W_REWARD-1:0] reward;
    logic [W_DATA-1:0]          weight;
  } node_t;

  function automatic logic signed [W_DATA-1:0] sat(
    input logic signed [W_ACC-1:0] x
  );
    if (x > W_ACC'(1023))
      return W_DATA'(1023);
    if (x < -W_ACC'(1024))
      return -W_DATA'(1024);
    return x[W_DATA-1:0];
  endfunction

endpackage

// File: rtl/treeval_node_mem.sv
// Single-port node table with per-field write strobes.
// Reads are combinational at the shared address.
module treeval_node_mem
  import treeval_pkg::*;
(
  input  logic              clk_i,
  input  logic [W_ADDR-1:0] addr_i,
  input  logic [W_DATA-1:0] data_i,
  input  logic              we_par_i,
  input  logic              we_act_i,
  input  logic              we_rew_i,
  input  logic              we_wgt_i,
  output node_t             node_o
);

  node_t mem_q [N_NODES];

  always_ff @(posedge clk_i) begin
    if (we_par_i)
      mem_q[addr_i].parent <= data_i[W_ADDR-1:0];
    if (we_act_i)
      mem_q[addr_i].action <= data_i[W_ACTION-1:0];
    if (we_rew_i)
      mem_q[addr_i].reward <= data_i;
    if (we_wgt_i)
      mem_q[addr_i].weight <= data_i;
  end

  assign node_o = mem_q[addr_i];

endmodule

// File: rtl/treeval_core.sv
// Bottom-up weighted tree evaluation: clear, accumulate leaves to
// root-level action sums, then select the best action.
module treeval_core
  import treeval_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_weight,
  input  logic                     mem_par,
  input  logic                     mem_rew,
  input  logic                     mem_act,
  input  logic [W_ADDR-1:0]        mem_addr,
  input  logic [W_DATA-1:0]        mem_data,
  input  logic                     conf_nodes,
  input  logic [W_CONF-1:0]        conf_data,
  output logic                     exp_change,
  output logic signed [W_DATA-1:0] exp,
  output logic [W_ACTION-1:0]      act
);

  state_e state_q, state_d;
  logic [W_ADDR-1:0] n_q, cnt_q;
  logic ph_q;
  logic in_idle, clr_en, rd_en, wr_en, sel_en;
  logic last_clr, to_root;

  node_t node_rd, node_q;
  logic [W_ADDR-1:0] nm_addr;

  logic signed [W_ACC-1:0] acc_q [N_NODES];
  logic signed [W_ACC-1:0] acc_rd, acc_wd, accn_q;
  logic [W_ADDR-1:0] acc_addr;
  logic acc_we;

  logic signed [W_ACC-1:0] rew_x, wgt_x, v, prod, c;
  logic signed [W_ACC-1:0] sum_q [N_ACT];
  logic [N_ACT-1:0] pres_q;
  logic signed [W_ACC-1:0] best_s;
  logic [W_ACTION-1:0] best_a;
  logic found;

  logic signed [W_DATA-1:0] exp_q;
  logic [W_ACTION-1:0] act_q;
  logic chg_q;

  assign last_clr = (n_q == cnt_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (conf_nodes) state_d = S_CLEAR;
      S_CLEAR:  if (last_clr)
                  state_d = (cnt_q == W_ADDR'(1)) ? S_SELECT : S_ACCUM;
      S_ACCUM:  if (ph_q && n_q == W_ADDR'(1)) state_d = S_SELECT;
      S_SELECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_idle = 1'b0;
    clr_en  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    sel_en  = 1'b0;
    case (state_q)
      S_IDLE:   in_idle = 1'b1;
      S_CLEAR:  clr_en  = 1'b1;
      S_ACCUM:  begin
                  rd_en = !ph_q;
                  wr_en = ph_q;
                end
      S_SELECT: sel_en  = 1'b1;
      default:  ;
    endcase
  end

  assign nm_addr = in_idle ? mem_addr : n_q;

  treeval_node_mem u_mem (
    .clk_i    (clk),
    .addr_i   (nm_addr),
    .data_i   (mem_data),
    .we_par_i (in_idle && mem_par),
    .we_act_i (in_idle && mem_act),
    .we_rew_i (in_idle && mem_rew),
    .we_wgt_i (in_idle && mem_weight),
    .node_o   (node_rd)
  );

  // Contribution of the node latched in the read phase.
  assign rew_x = {{(W_ACC-W_REWARD){node_q.reward[W_REWARD-1]}},
                  node_q.reward};
  assign wgt_x = {{(W_ACC-W_DATA){1'b0}}, node_q.weight};
  assign v     = rew_x + accn_q;
  assign prod  = wgt_x * v;
  assign c     = prod >>> 10;
  assign to_root = (node_q.parent == '0);

  assign acc_addr = wr_en ? node_q.parent : n_q;
  assign acc_rd   = acc_q[acc_addr];
  assign acc_we   = !rst && (clr_en || (wr_en && !to_root));
  assign acc_wd   = clr_en ? '0 : acc_rd + c;

  always_ff @(posedge clk) begin
    if (acc_we) acc_q[acc_addr] <= acc_wd;
    if (rd_en && !rst) begin
      node_q <= node_rd;
      accn_q <= acc_rd;
    end
  end

  // Strict compare keeps the lowest action on ties.
  always_comb begin
    best_s = '0;
    best_a = '0;
    found  = 1'b0;
    for (int i = 0; i < N_ACT; i++) begin
      if (pres_q[i] && (!found || sum_q[i] > best_s)) begin
        best_s = sum_q[i];
        best_a = W_ACTION'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q    <= '0;
      cnt_q  <= W_ADDR'(1);
      ph_q   <= 1'b0;
      pres_q <= '0;
      for (int i = 0; i < N_ACT; i++) sum_q[i] <= '0;
      exp_q  <= '0;
      act_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      chg_q <= sel_en;
      case (state_q)
        S_IDLE: if (conf_nodes) begin
          cnt_q <= (conf_data == '0) ? W_ADDR'(1) : conf_data;
          n_q   <= '0;
          ph_q  <= 1'b0;
        end
        S_CLEAR: begin
          if (!last_clr) n_q <= n_q + 1'b1;
          if (n_q == '0) begin
            pres_q <= '0;
            for (int i = 0; i < N_ACT; i++) sum_q[i] <= '0;
          end
        end
        S_ACCUM: begin
          ph_q <= !ph_q;
          if (ph_q) begin
            n_q <= n_q - 1'b1;
            if (to_root) begin
              sum_q[node_q.action]  <= sum_q[node_q.action] + c;
              pres_q[node_q.action] <= 1'b1;
            end
          end
        end
        S_SELECT: begin
          exp_q <= sat(best_s);
          act_q <= best_a;
        end
        default: ;
      endcase
    end
  end

  assign exp        = exp_q;
  assign act        = act_q;
  assign exp_change = chg_q;

endmodule

// File: tb/tb_treeval_core.sv
// Directed bench for treeval_core: hand-computed tree results,
// latency, saturation, ties, reset abort and ignored writes.
module tb_treeval_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_weight, mem_par, mem_rew, mem_act;
  logic [9:0]  mem_addr;
  logic [10:0] mem_data;
  logic        conf_nodes;
  logic [9:0]  conf_data;
  logic        exp_change;
  logic signed [10:0] exp;
  logic [2:0]  act;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  treeval_core dut (
    .clk        (clk),
    .rst        (rst),
    .mem_weight (mem_weight),
    .mem_par    (mem_par),
    .mem_rew    (mem_rew),
    .mem_act    (mem_act),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .conf_nodes (conf_nodes),
    .conf_data  (conf_data),
    .exp_change (exp_change),
    .exp        (exp),
    .act        (act)
  );

  task automatic chk(input string tag, input int got, input int want);
    ntot++;
    assert (got === want) npass++;
    else $error("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  task automatic wr(input logic [9:0] a, input int par, input int ac,
                    input int rew, input int w);
    @(negedge clk);
    mem_addr = a;
    mem_data = 11'(par); mem_par = 1'b1;
    @(negedge clk);
    mem_par = 1'b0; mem_data = 11'(ac); mem_act = 1'b1;
    @(negedge clk);
    mem_act = 1'b0; mem_data = 11'(rew); mem_rew = 1'b1;
    @(negedge clk);
    mem_rew = 1'b0; mem_data = 11'(w); mem_weight = 1'b1;
    @(negedge clk);
    mem_weight = 1'b0;
  endtask

  // Starts a run and returns edge count to the pulse (0 = timeout).
  task automatic run(input int n, input bit inject, output int lat,
                     output int width);
    lat = 0;
    width = 0;
    @(negedge clk);
    conf_data  = 10'(n);
    conf_nodes = 1'b1;
    @(posedge clk);
    #1 conf_nodes = 1'b0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (inject && k == 2) begin
        mem_addr = 10'd1; mem_data = 11'd500; mem_rew = 1'b1;
      end
      if (inject && k == 3) mem_rew = 1'b0;
      if (exp_change) lat = k;
    end
    if (lat != 0) begin
      width = 1;
      @(posedge clk);
      #1 if (exp_change) width = 2;
    end
  endtask

  int lat, wid;

  initial begin
    rst = 1'b1;
    {mem_weight, mem_par, mem_rew, mem_act, conf_nodes} = '0;
    mem_addr = '0; mem_data = '0; conf_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_exp", int'(exp), 0);
    chk("reset_act", int'(act), 0);
    chk("reset_chg", int'(exp_change), 0);
    rst = 1'b0;

    // Two-branch tree
    wr(10'd1, 0, 2, 100, 512);
    wr(10'd2, 0, 5, -40, 1024);
    run(3, 1'b0, lat, wid);
    chk("two_lat", lat, 8);
    chk("two_width", wid, 1);
    chk("two_exp", int'(exp), 50);
    chk("two_act", int'(act), 2);

    // Deep chain
    wr(10'd1, 0, 1, 10, 1024);
    wr(10'd2, 1, 0, 20, 512);
    run(3, 1'b0, lat, wid);
    chk("chain_lat", lat, 8);
    chk("chain_exp", int'(exp), 20);
    chk("chain_act", int'(act), 1);

    // Saturation
    wr(10'd1, 0, 3, 1000, 1024);
    wr(10'd2, 1, 0, 1000, 1024);
    run(3, 1'b0, lat, wid);
    chk("sat_exp", int'(exp), 1023);
    chk("sat_act", int'(act), 3);

    // Tie with floor truncation: (512*-3)>>>10 = -2
    wr(10'd1, 0, 4, -3, 512);
    wr(10'd2, 0, 6, -3, 512);
    run(3, 1'b0, lat, wid);
    chk("tie_exp", int'(exp), -2);
    chk("tie_act", int'(act), 4);

    // N=0 runs as N=1: nothing present
    run(0, 1'b0, lat, wid);
    chk("n0_lat", lat, 2);
    chk("n0_exp", int'(exp), 0);
    chk("n0_act", int'(act), 0);

    // Reset mid-ACCUM aborts without a pulse
    wr(10'd1, 0, 2, 100, 512);
    wr(10'd2, 0, 5, -40, 1024);
    wr(10'd7, 0, 1, 300, 1024);
    run(3, 1'b0, lat, wid);
    chk("pre_rst_exp", int'(exp), 50);
    @(negedge clk);
    conf_data = 10'd8; conf_nodes = 1'b1;
    @(negedge clk);
    conf_nodes = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (exp_change) lat = 1;
    end
    chk("abort_nopulse", lat, 0);
    chk("abort_exp", int'(exp), 0);
    chk("abort_act", int'(act), 0);

    // Rerun with a write during computation, then confirm table intact
    run(3, 1'b1, lat, wid);
    chk("rerun_lat", lat, 8);
    chk("rerun_exp", int'(exp), 50);
    chk("rerun_act", int'(act), 2);
    run(3, 1'b0, lat, wid);
    chk("keep_exp", int'(exp), 50);
    run(8, 1'b0, lat, wid);
    chk("n8_lat", lat, 23);
    chk("n8_exp", int'(exp), 300);
    chk("n8_act", int'(act), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
